// File: rtl/rns_33_32_31_pkg.sv
// Shared constants and types for the {33, 32, 31} residue number system.
package rns_33_32_31_pkg;

    localparam int M1 = 33;
    localparam int M2 = 32;
    localparam int M3 = 31;
    localparam int M  = 32736;

    localparam int W1 = 6;
    localparam int W2 = 5;
    localparam int W3 = 5;
    localparam int WB = 15;

    // Chunk width used when splitting the binary operand (32 = 2^5).
    localparam int WC = 5;

    // Width of the un-reduced chunk sums (max 95).
    localparam int WS = 7;

    // First value outside the dynamic range.
    localparam logic [WB-1:0] X_LIMIT = WB'(M);

    // Stage-1 pipeline payload: partial sums awaiting reduction.
    typedef struct packed {
        logic [WS-1:0] s31;
        logic [WS-1:0] s33;
        logic [WC-1:0] c0;
        logic          rng;
    } s1_t;

endpackage

// File: rtl/mod31_fold.sv
// End-around-carry reduction of a 7-bit sum (0..127) to a residue mod 31.
module mod31_fold
    import rns_33_32_31_pkg::*;
(
    input  logic [WS-1:0] sum,
    output logic [W3-1:0] res
);

    logic [5:0]    t;
    logic [W3-1:0] u;

    // Two folds (32 == 1 mod 31) then map the double representation of zero.
    always_comb begin
        t   = {1'b0, sum[4:0]} + {4'b0, sum[6:5]};
        // t <= 34, so the second fold never carries out of 5 bits.
        u   = t[4:0] + {4'b0, t[5]};
        res = (u == 5'd31) ? 5'd0 : u;
    end

endmodule

// File: rtl/forward_converter_33_32_31.sv
// Two-stage binary-to-RNS forward converter for moduli {33, 32, 31}
// with valid/ready handshaking on both sides.
module forward_converter_33_32_31
    import rns_33_32_31_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WB-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W1-1:0] x1,
    output logic [W2-1:0] x2,
    output logic [W3-1:0] x3,
    output logic          range_err,
    output logic          err_sticky
);

    logic          v1_reg;
    logic          v2_reg;
    logic          adv1;
    logic          adv2;
    s1_t           s1_reg;
    s1_t           s1_next;
    logic [WC-1:0] chunk [3];
    logic [W1-1:0] x1_next;
    logic [W3-1:0] x3_next;
    logic [W1-1:0] x1_reg;
    logic [W2-1:0] x2_reg;
    logic [W3-1:0] x3_reg;
    logic          range_err_reg;
    logic          err_sticky_reg;

    // Split the operand into base-32 digits.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chunk
        assign chunk[gi] = in_data[gi*WC +: WC];
    end

    // Backpressure chain: a stage advances when its successor can take data.
    assign adv2      = ~v2_reg | out_ready;
    assign adv1      = ~v1_reg | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_reg;

    // Stage-1 arithmetic: digit sums exploiting 32 == 1 (mod 31) and 32 == -1 (mod 33).
    always_comb begin
        s1_next.s31 = {2'b0, chunk[0]} + {2'b0, chunk[1]} + {2'b0, chunk[2]};
        // 33 - c1 keeps the mod-33 sum non-negative (range 2..95).
        s1_next.s33 = {2'b0, chunk[0]} + {2'b0, chunk[2]}
                    + (WS'(M1) - {2'b0, chunk[1]});
        s1_next.c0  = chunk[0];
        s1_next.rng = (in_data >= X_LIMIT);
    end

    mod31_fold u_fold31 (
        .sum (s1_reg.s31),
        .res (x3_next)
    );

    // Stage-2 mod-33 reduction by conditional subtraction of 66 then 33.
    always_comb begin
        logic [WS-1:0] a;
        logic [WS-1:0] b;
        a       = (s1_reg.s33 >= WS'(2*M1)) ? s1_reg.s33 - WS'(2*M1) : s1_reg.s33;
        b       = (a >= WS'(M1)) ? a - WS'(M1) : a;
        x1_next = W1'(b);
    end

    // Stage-1 registers: load whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            s1_reg <= '0;
        end else if (adv1) begin
            v1_reg <= in_valid;
            s1_reg <= s1_next;
        end
    end

    // Stage-2 (output) registers: hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg        <= 1'b0;
            x1_reg        <= '0;
            x2_reg        <= '0;
            x3_reg        <= '0;
            range_err_reg <= 1'b0;
        end else if (adv2) begin
            v2_reg        <= v1_reg;
            x1_reg        <= x1_next;
            x2_reg        <= s1_reg.c0;
            x3_reg        <= x3_next;
            range_err_reg <= s1_reg.rng;
        end
    end

    // Sticky error: any accepted out-of-range operand, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_reg <= 1'b0;
        end else if (in_valid && adv1 && s1_next.rng) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign x1         = x1_reg;
    assign x2         = x2_reg;
    assign x3         = x3_reg;
    assign range_err  = range_err_reg;
    assign err_sticky = err_sticky_reg;

endmodule
